// File: rtl/game_timer.sv
// MM:SS BCD level timer with prescaled tick, up/down count, pause, clear and clamped load.
// Down-count latches expired at 00:00; up-count pulses wrapped when rolling over full scale.
module game_timer #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned MIN_TENS_MAX = 9
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        run,
  input  logic        mode,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic [15:0] digits,
  output logic        tick,
  output logic        expired,
  output logic        wrapped
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [3:0]    MT_MAX     = 4'(MIN_TENS_MAX);

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  mmss_t         cnt_q, cnt_d;
  mmss_t         load_val, up_val, dn_val, step_val;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          expired_q, expired_d;
  logic          wrapped_q, wrapped_d;
  logic          up_wrap;

  // Per-digit clamp so the display never sees a non-BCD or out-of-range digit
  always_comb begin
    load_val = mmss_t'(load_bcd);
    if (load_val.sec_ones > 4'd9)   load_val.sec_ones = 4'd9;
    if (load_val.sec_tens > 4'd5)   load_val.sec_tens = 4'd5;
    if (load_val.min_ones > 4'd9)   load_val.min_ones = 4'd9;
    if (load_val.min_tens > MT_MAX) load_val.min_tens = MT_MAX;
  end

  // Up step with ripple carry; full scale rolls to 00:00
  always_comb begin
    up_val  = cnt_q;
    up_wrap = 1'b0;
    if (cnt_q.sec_ones < 4'd9) begin
      up_val.sec_ones = cnt_q.sec_ones + 4'd1;
    end else begin
      up_val.sec_ones = 4'd0;
      if (cnt_q.sec_tens < 4'd5) begin
        up_val.sec_tens = cnt_q.sec_tens + 4'd1;
      end else begin
        up_val.sec_tens = 4'd0;
        if (cnt_q.min_ones < 4'd9) begin
          up_val.min_ones = cnt_q.min_ones + 4'd1;
        end else begin
          up_val.min_ones = 4'd0;
          if (cnt_q.min_tens < MT_MAX) begin
            up_val.min_tens = cnt_q.min_tens + 4'd1;
          end else begin
            up_val.min_tens = 4'd0;
            up_wrap         = 1'b1;
          end
        end
      end
    end
  end

  // Down step with ripple borrow; 00:00 holds
  always_comb begin
    dn_val = cnt_q;
    if (cnt_q != '0) begin
      if (cnt_q.sec_ones != 4'd0) begin
        dn_val.sec_ones = cnt_q.sec_ones - 4'd1;
      end else begin
        dn_val.sec_ones = 4'd9;
        if (cnt_q.sec_tens != 4'd0) begin
          dn_val.sec_tens = cnt_q.sec_tens - 4'd1;
        end else begin
          dn_val.sec_tens = 4'd5;
          if (cnt_q.min_ones != 4'd0) begin
            dn_val.min_ones = cnt_q.min_ones - 4'd1;
          end else begin
            dn_val.min_ones = 4'd9;
            dn_val.min_tens = cnt_q.min_tens - 4'd1;
          end
        end
      end
    end
  end

  assign step_val = mode ? dn_val : up_val;

  // Control priority: clear, then load, then prescaled step
  always_comb begin
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    tick_d    = 1'b0;
    wrapped_d = 1'b0;
    expired_d = expired_q;
    if (clear) begin
      cnt_d     = '0;
      presc_d   = '0;
      expired_d = 1'b0;
    end else if (load) begin
      cnt_d     = load_val;
      presc_d   = '0;
      expired_d = 1'b0;
    end else if (run && !expired_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d   = '0;
        cnt_d     = step_val;
        tick_d    = 1'b1;
        wrapped_d = !mode && up_wrap;
        expired_d = mode && (step_val == '0);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign digits  = cnt_q;
  assign tick    = tick_q;
  assign expired = expired_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer at DIV=4: count, carry/wrap, expiry, pause, clamp, reset.
module tb_game_timer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run, mode, clear, load;
  logic [15:0] load_bcd;
  logic [15:0] digits;
  logic        tick, expired, wrapped;

  int total = 0;
  int bad   = 0;

  game_timer #(.CLK_HZ(4), .TICK_HZ(1), .MIN_TENS_MAX(9)) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .run     (run),
    .mode    (mode),
    .clear   (clear),
    .load    (load),
    .load_bcd(load_bcd),
    .digits  (digits),
    .tick    (tick),
    .expired (expired),
    .wrapped (wrapped)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_bcd = v;
    edges(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; run = 1'b0; mode = 1'b0; clear = 1'b0; load = 1'b0; load_bcd = '0;
    #12;
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL rst_digits got=%h want=0000", digits); end
    total++; if ({tick, expired, wrapped} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {tick, expired, wrapped}); end
    @(negedge clk) resetn = 1'b1;
    edges(1);
  endtask

  task automatic test_count_up;
    int nt;
    nt = 0;
    clear = 1'b1; edges(1); clear = 1'b0;
    run = 1'b1; mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      edges(1);
      if (tick === 1'b1) nt++;
      total++;
      if (tick !== ((i % 4) == 3)) begin bad++; $display("FAIL up_tick_c%0d got=%b want=%b", i + 1, tick, (i % 4) == 3); end
    end
    total++; if (digits !== 16'h0010) begin bad++; $display("FAIL up_digits got=%h want=0010", digits); end
    total++; if (nt !== 10) begin bad++; $display("FAIL up_ntick got=%0d want=10", nt); end
    run = 1'b0;
  endtask

  task automatic test_carry_wrap;
    mode = 1'b0; run = 1'b1;
    do_load(16'h0959);
    total++; if (digits !== 16'h0959) begin bad++; $display("FAIL cw_load got=%h want=0959", digits); end
    edges(3);
    total++; if ({digits, tick} !== {16'h0959, 1'b0}) begin bad++; $display("FAIL cw_hold got=%h/%b want=0959/0", digits, tick); end
    edges(1);
    total++; if ({digits, tick} !== {16'h1000, 1'b1}) begin bad++; $display("FAIL cw_carry got=%h/%b want=1000/1", digits, tick); end
    do_load(16'h9959);
    for (int k = 0; k < 4; k++) begin
      edges(1);
      total++;
      if (wrapped !== (k == 3)) begin bad++; $display("FAIL cw_wrap_c%0d got=%b want=%b", k + 1, wrapped, k == 3); end
    end
    total++; if ({digits, expired} !== {16'h0000, 1'b0}) begin bad++; $display("FAIL cw_zero got=%h/%b want=0000/0", digits, expired); end
    edges(1);
    total++; if (wrapped !== 1'b0) begin bad++; $display("FAIL cw_wrap_pulse got=%b want=0", wrapped); end
    run = 1'b0;
  endtask

  task automatic test_countdown_expire;
    int nt;
    nt = 0;
    mode = 1'b1; run = 1'b1;
    do_load(16'h0002);
    edges(4);
    total++; if ({digits, tick, expired} !== {16'h0001, 1'b1, 1'b0}) begin bad++; $display("FAIL cd_one got=%h/%b/%b want=0001/1/0", digits, tick, expired); end
    edges(3);
    total++; if (expired !== 1'b0) begin bad++; $display("FAIL cd_early_exp got=%b want=0", expired); end
    edges(1);
    total++; if ({digits, tick, expired} !== {16'h0000, 1'b1, 1'b1}) begin bad++; $display("FAIL cd_zero got=%h/%b/%b want=0000/1/1", digits, tick, expired); end
    for (int i = 0; i < 20; i++) begin
      if (i == 10) mode = 1'b0;
      edges(1);
      if (tick === 1'b1) nt++;
    end
    total++; if (nt !== 0) begin bad++; $display("FAIL cd_halt_ticks got=%0d want=0", nt); end
    total++; if ({digits, expired} !== {16'h0000, 1'b1}) begin bad++; $display("FAIL cd_halt got=%h/%b want=0000/1", digits, expired); end
    mode = 1'b1;
    do_load(16'h0100);
    total++; if ({digits, expired} !== {16'h0100, 1'b0}) begin bad++; $display("FAIL cd_reload got=%h/%b want=0100/0", digits, expired); end
    edges(4);
    total++; if ({digits, tick} !== {16'h0059, 1'b1}) begin bad++; $display("FAIL cd_borrow got=%h/%b want=0059/1", digits, tick); end
    run = 1'b0;
  endtask

  task automatic test_load_zero_down;
    mode = 1'b1; run = 1'b1;
    do_load(16'h0000);
    for (int i = 0; i < 3; i++) begin
      edges(1);
      total++;
      if ({tick, expired} !== 2'b00) begin bad++; $display("FAIL lz_wait_c%0d got=%b want=00", i + 1, {tick, expired}); end
    end
    edges(1);
    total++; if ({digits, tick, expired} !== {16'h0000, 1'b1, 1'b1}) begin bad++; $display("FAIL lz_expire got=%h/%b/%b want=0000/1/1", digits, tick, expired); end
    run = 1'b0;
  endtask

  task automatic test_pause;
    mode = 1'b0; run = 1'b1;
    clear = 1'b1; edges(1); clear = 1'b0;
    edges(2);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      total++;
      if ({digits, tick} !== {16'h0000, 1'b0}) begin bad++; $display("FAIL ps_frozen_c%0d got=%h/%b want=0000/0", i + 1, digits, tick); end
    end
    run = 1'b1;
    edges(1);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL ps_resume1 got=%b want=0", tick); end
    edges(1);
    total++; if ({digits, tick} !== {16'h0001, 1'b1}) begin bad++; $display("FAIL ps_resume2 got=%h/%b want=0001/1", digits, tick); end
    run = 1'b0;
  endtask

  task automatic test_mode_change;
    mode = 1'b0; run = 1'b1;
    clear = 1'b1; edges(1); clear = 1'b0;
    edges(20);
    total++; if (digits !== 16'h0005) begin bad++; $display("FAIL mc_five got=%h want=0005", digits); end
    edges(3);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL mc_pre got=%b want=0", tick); end
    mode = 1'b1;
    edges(1);
    total++; if ({digits, tick} !== {16'h0004, 1'b1}) begin bad++; $display("FAIL mc_down got=%h/%b want=0004/1", digits, tick); end
    edges(1);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL mc_post got=%b want=0", tick); end
    run = 1'b0;
  endtask

  task automatic test_clamp_clear;
    run = 1'b0; mode = 1'b0;
    do_load(16'hFAFF);
    total++; if (digits !== 16'h9959) begin bad++; $display("FAIL cl_clamp got=%h want=9959", digits); end
    do_load(16'h3A7C);
    total++; if (digits !== 16'h3959) begin bad++; $display("FAIL cl_clamp2 got=%h want=3959", digits); end
    clear = 1'b1; load = 1'b1; load_bcd = 16'h1234;
    edges(1);
    clear = 1'b0; load = 1'b0;
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL cl_prio got=%h want=0000", digits); end
    run = 1'b1;
    do_load(16'h0003);
    edges(2);
    clear = 1'b1; edges(1); clear = 1'b0;
    edges(3);
    total++; if ({digits, tick} !== {16'h0000, 1'b0}) begin bad++; $display("FAIL cl_restart3 got=%h/%b want=0000/0", digits, tick); end
    edges(1);
    total++; if ({digits, tick} !== {16'h0001, 1'b1}) begin bad++; $display("FAIL cl_restart4 got=%h/%b want=0001/1", digits, tick); end
    run = 1'b0;
  endtask

  task automatic test_async_reset;
    mode = 1'b0; run = 1'b1;
    do_load(16'h0120);
    edges(4);
    total++; if ({digits, tick} !== {16'h0121, 1'b1}) begin bad++; $display("FAIL ar_pre got=%h/%b want=0121/1", digits, tick); end
    #2 resetn = 1'b0;
    #1;
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL ar_digits got=%h want=0000", digits); end
    total++; if ({tick, expired, wrapped} !== 3'b000) begin bad++; $display("FAIL ar_flags got=%b want=000", {tick, expired, wrapped}); end
    run = 1'b0;
    @(negedge clk) resetn = 1'b1;
    edges(3);
    total++; if (digits !== 16'h0000) begin bad++; $display("FAIL ar_after got=%h want=0000", digits); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_carry_wrap();
    test_countdown_expire();
    test_load_zero_down();
    test_pause();
    test_mode_change();
    test_clamp_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
